fifo_multi_read: RTL and testbench



---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_rd_port.sv | 62 ++++++
 rtl/fifo_multi_read.sv | 97 +++++++++
 tb/tb_fifo_multi_read.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: width calculation, pointer wrap, level width.
// Used by fifo_multi_read and the existing single/dual-reader FIFOs.
package fifo_pkg;

    function automatic int unsigned clog2_w(input int unsigned val);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(val)) w++;
        return w;
    endfunction

    // Explicit compare so non-power-of-two depths wrap correctly.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int unsigned lvl_width(input int unsigned depth);
        return clog2_w(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_port.sv
// One reader of the broadcast FIFO: read pointer, level counter, output registers.
// Optional FIFO_MULTI_READ_ERR_EN adds a sticky underflow flag.
module fifo_rd_port
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 2560,
    localparam int PTR_W     = clog2_w(DEPTH),
    localparam int LVL_W     = lvl_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic                  wr_accept,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [PTR_W-1:0]      rd_ptr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic [LVL_W-1:0]      level
`ifdef FIFO_MULTI_READ_ERR_EN
    ,
    output logic                  err_underflow
`endif
);

    logic rd_accept;

    assign empty     = (level == '0);
    assign rd_accept = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                rd_data <= mem_data;
                rd_ptr  <= PTR_W'(ptr_next(32'(rd_ptr), DEPTH));
            end
            // A write can never meet a full reader here: full blocks it upstream.
            case ({wr_accept, rd_accept})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef FIFO_MULTI_READ_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_underflow <= 1'b0;
        else if (rd_en & empty)
            err_underflow <= 1'b1;
    end
`endif

endmodule

// File: rtl/fifo_multi_read.sv
// Single-write, NUM_RD-read broadcast FIFO; backpressure follows the slowest reader.
// Optional FIFO_MULTI_READ_ERR_EN adds sticky err_overflow / err_underflow outputs.
module fifo_multi_read
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH        = 128,
    parameter int DEPTH             = 2560,
    parameter int NUM_RD            = 2,
    parameter int ALMOST_FULL_THRES = 10,
    localparam int LVL_W            = lvl_width(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         wr_en,
    output logic                         full,
    output logic                         almost_full,
    input  logic [NUM_RD-1:0]            rd_en,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic [NUM_RD-1:0]            empty,
    output logic [NUM_RD*LVL_W-1:0]      level
`ifdef FIFO_MULTI_READ_ERR_EN
    ,
    output logic                         err_overflow,
    output logic [NUM_RD-1:0]            err_underflow
`endif
);

    localparam int PTR_W = clog2_w(DEPTH);
    localparam int NR_P2 = 1 << clog2_w(NUM_RD);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr [NUM_RD];
    logic                  wr_accept;
    logic [LVL_W-1:0]      node [2*NR_P2-1];
    logic [LVL_W-1:0]      max_lvl;

    assign wr_accept = wr_en & ~full;

    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            wr_ptr <= '0;
        else if (wr_accept)
            wr_ptr <= PTR_W'(ptr_next(32'(wr_ptr), DEPTH));
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        fifo_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_rd_port (
            .clk           (clk),
            .rst           (rst),
            .rd_en         (rd_en[g]),
            .wr_accept     (wr_accept),
            .mem_data      (mem[rd_ptr[g]]),
            .rd_ptr        (rd_ptr[g]),
            .rd_data       (rd_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .rd_valid      (rd_valid[g]),
            .empty         (empty[g]),
            .level         (level[g*LVL_W +: LVL_W])
`ifdef FIFO_MULTI_READ_ERR_EN
            ,
            .err_underflow (err_underflow[g])
`endif
        );
    end

    // Binary max tree: leaves at NR_P2-1.., unused leaves padded with zero.
    always_comb begin
        for (int i = 0; i < 2*NR_P2-1; i++) node[i] = '0;
        for (int i = 0; i < NUM_RD; i++) node[NR_P2-1+i] = level[i*LVL_W +: LVL_W];
        for (int i = NR_P2-2; i >= 0; i--)
            node[i] = (node[2*i+1] > node[2*i+2]) ? node[2*i+1] : node[2*i+2];
    end

    assign max_lvl     = node[0];
    assign full        = (max_lvl == LVL_W'(DEPTH));
    assign almost_full = ((DEPTH - int'(max_lvl)) <= ALMOST_FULL_THRES);

`ifdef FIFO_MULTI_READ_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_overflow <= 1'b0;
        else if (wr_en & full)
            err_overflow <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fifo_multi_read.sv
// Bench for fifo_multi_read: directed scenarios plus random traffic against a queue model.
module tb_fifo_multi_read;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int NRD   = 3;
    localparam int AFT   = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     wr_data;
    logic              wr_en;
    logic              full, almost_full;
    logic [NRD-1:0]    rd_en, rd_valid, empty;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD*LW-1:0] level;
`ifdef FIFO_MULTI_READ_ERR_EN
    logic              err_overflow;
    logic [NRD-1:0]    err_underflow;
    logic              m_err_ov;
    logic [NRD-1:0]    m_err_un;
`endif

    fifo_multi_read #(
        .DATA_WIDTH        (DW),
        .DEPTH             (DEPTH),
        .NUM_RD            (NRD),
        .ALMOST_FULL_THRES (AFT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .full          (full),
        .almost_full   (almost_full),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .empty         (empty),
        .level         (level)
`ifdef FIFO_MULTI_READ_ERR_EN
        ,
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: each reader owns a queue of its unread words.
    logic [DW-1:0] q [NRD][$];
    logic [DW-1:0] last_data [NRD];
    logic          exp_valid [NRD];
    logic [DW-1:0] next_word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_max();
        int m = 0;
        for (int i = 0; i < NRD; i++) if (q[i].size() > m) m = q[i].size();
        return m;
    endfunction

    task automatic compare_all();
        int m;
        m = model_max();
        check("full", 32'(full), 32'(m == DEPTH));
        check("almost_full", 32'(almost_full), 32'((DEPTH - m) <= AFT));
        for (int i = 0; i < NRD; i++) begin
            check($sformatf("level%0d", i), 32'(level[i*LW +: LW]), 32'(q[i].size()));
            check($sformatf("empty%0d", i), 32'(empty[i]), 32'(q[i].size() == 0));
            check($sformatf("rd_valid%0d", i), 32'(rd_valid[i]), 32'(exp_valid[i]));
            check($sformatf("rd_data%0d", i), 32'(rd_data[i*DW +: DW]), 32'(last_data[i]));
        end
`ifdef FIFO_MULTI_READ_ERR_EN
        check("err_overflow", 32'(err_overflow), 32'(m_err_ov));
        check("err_underflow", 32'(err_underflow), 32'(m_err_un));
`endif
    endtask

    task automatic model_clear();
        for (int i = 0; i < NRD; i++) begin
            q[i].delete();
            last_data[i] = '0;
            exp_valid[i] = 1'b0;
        end
`ifdef FIFO_MULTI_READ_ERR_EN
        m_err_ov = 1'b0;
        m_err_un = '0;
`endif
    endtask

    task automatic do_reset(input logic [NRD-1:0] r);
        rst   = 1'b1;
        rd_en = r;
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        rd_en = '0;
        model_clear();
        compare_all();
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic [NRD-1:0] r);
        logic m_full;
        m_full  = (model_max() == DEPTH);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
`ifdef FIFO_MULTI_READ_ERR_EN
        if (w && m_full) m_err_ov = 1'b1;
        for (int i = 0; i < NRD; i++) if (r[i] && q[i].size() == 0) m_err_un[i] = 1'b1;
`endif
        for (int i = 0; i < NRD; i++) begin
            if (r[i] && q[i].size() > 0) begin
                last_data[i] = q[i].pop_front();
                exp_valid[i] = 1'b1;
            end else begin
                exp_valid[i] = 1'b0;
            end
        end
        if (w && !m_full)
            for (int i = 0; i < NRD; i++) q[i].push_back(d);
        wr_en = 1'b0;
        rd_en = '0;
        compare_all();
    endtask

    task automatic write_next();
        step(1'b1, next_word, '0);
        next_word++;
    endtask

    initial begin
        int pw, pr;
        logic [NRD-1:0] r;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_data   = '0;
        rd_en     = '0;
        next_word = 16'h0001;
        model_clear();
        do_reset('0);
        check("reset_empty", 32'(empty), 32'h7);

        // Three words, then reader 1 drains them.
        repeat (3) write_next();
        check("lvl_after_3", 32'(level), {20'd0, 4'd3, 4'd3, 4'd3});
        repeat (3) step(1'b0, '0, 3'b010);
        check("lvl_after_rd1", 32'(level), {20'd0, 4'd3, 4'd0, 4'd3});
        check("rd1_last", 32'(rd_data[DW +: DW]), 32'h3);

        // Fill to full, drop the overflow write, reader 0 drains all.
        do_reset('0);
        next_word = 16'h0001;
        repeat (5) write_next();
        check("af_at_5", 32'(almost_full), 32'h0);
        write_next();
        check("af_at_6", 32'(almost_full), 32'h1);
        repeat (2) write_next();
        check("full_at_8", 32'(full), 32'h1);
        step(1'b1, 16'hdead, '0);
        check("lvl_after_drop", 32'(level[0 +: LW]), 32'd8);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, '0, 3'b001);
            check("rd0_order", 32'(rd_data[0 +: DW]), 32'(k + 1));
        end
        check("full_slow_readers", 32'(full), 32'h1);
        repeat (8) step(1'b0, '0, 3'b010);
        check("full_rd2_idle", 32'(full), 32'h1);
        step(1'b0, '0, 3'b100);
        check("full_clear", 32'(full), 32'h0);

        // Continuous streaming across pointer wrap.
        repeat (20) write_nextless_stream();

        // Reads on empty readers.
        repeat (10) step(1'b0, '0, 3'b111);
        step(1'b0, '0, 3'b011);
        check("empty_rd_valid", 32'(rd_valid), 32'h0);

        // Reset with level 5 and a read in flight.
        repeat (5) write_next();
        step(1'b0, '0, 3'b111);
        do_reset(3'b111);
        check("rst_empty", 32'(empty), 32'h7);
        check("rst_valid", 32'(rd_valid), 32'h0);

        // Random traffic with per-epoch write/read biases.
        for (int e = 0; e < 12; e++) begin
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int c = 0; c < 60; c++) begin
                for (int i = 0; i < NRD; i++) r[i] = ($urandom_range(0, 99) < pr);
                step(($urandom_range(0, 99) < pw), DW'($urandom), r);
            end
            if (e == 6) do_reset(NRD'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic write_nextless_stream();
        step(1'b1, next_word, 3'b111);
        next_word++;
    endtask

endmodule
